// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: one byte lane per requester
// plus the per-requester accept pulse.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   ack;

   // Requesters drive bytes and see the accept pulse
   modport master (output req, output req_data, output req_last, input ack);

   // Arbiter samples bytes and returns the accept pulse
   modport slave  (input req, input req_data, input req_last, output ack);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte requesters.
// Round-robin per byte, one byte in flight, sequenced as
// IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE. Keeps a 16-bit sent-byte
// counter and a sticky timeout flag for a transmitter that never goes busy.
// Optional feature: define UART_ARB_LOCK_EN to keep packets contiguous by
// locking the grant to a requester until it issues a byte with req_last=1.
// tx_wr and ack are the registered image of the ISSUE cycle, so they are
// visible one cycle after ISSUE, two cycles after the request is sampled.
module uart_tx_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned BUSY_TO = 64
) (
   input  logic                 clk,
   input  logic                 resetb,
   uart_tx_arbiter_if.slave     bus,
   output logic [7:0]           tx_data,
   output logic                 tx_wr,
   input  logic                 tx_busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 active,
   output logic                 to_err,
   output logic [15:0]          sent_cnt
);

   localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 8;

`ifdef UART_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [IDW-1:0]    ptr;
   logic [CW-1:0]     to_cnt;
   logic              last_q;
   logic              locked;
   logic [NREQ-1:0]   ack_q;

   logic [NREQ-1:0]   elig_c;
   logic              pick_vld_c;
   logic [IDW-1:0]    pick_id_c;
   logic [7:0]        pick_data_c;
   logic              pick_last_c;
   logic [SW-1:0]     j_c;
   logic              done_c;

   assign bus.ack = ack_q;

   // Byte completes when the transmitter drops busy after having raised it
   assign done_c = (state == WAIT_DONE) && !tx_busy;

   // Round-robin pick starting at ptr; a held lock narrows the field to one requester
   always_comb begin
      elig_c      = bus.req;
      pick_vld_c  = 1'b0;
      pick_id_c   = '0;
      pick_data_c = '0;
      pick_last_c = 1'b0;
      j_c         = '0;
      if (locked) begin
         elig_c = '0;
         elig_c[grant_id] = bus.req[grant_id];
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         j_c = SW'((32'(ptr) + k) % NREQ);
         if (!pick_vld_c && elig_c[j_c]) begin
            pick_vld_c  = 1'b1;
            pick_id_c   = IDW'(j_c);
            pick_data_c = 8'(bus.req_data >> (8 * int'(j_c)));
            pick_last_c = bus.req_last[j_c];
         end
      end
   end

   // Arbiter FSM with all outputs registered
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state    <= IDLE;
         ptr      <= '0;
         to_cnt   <= '0;
         last_q   <= 1'b0;
         locked   <= 1'b0;
         ack_q    <= '0;
         tx_data  <= '0;
         tx_wr    <= 1'b0;
         grant_id <= '0;
         active   <= 1'b0;
         to_err   <= 1'b0;
         sent_cnt <= '0;
      end else begin
         ack_q    <= '0;
         tx_wr    <= 1'b0;
         sent_cnt <= sent_cnt + 16'(done_c);
         case (state)
            IDLE: begin
               if (!tx_busy && pick_vld_c) begin
                  grant_id <= pick_id_c;
                  tx_data  <= pick_data_c;
                  last_q   <= pick_last_c;
                  active   <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               tx_wr  <= 1'b1;
               ack_q  <= NREQ'(1) << grant_id;
               ptr    <= (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
               locked <= LOCK_EN && !last_q;
               to_cnt <= '0;
               state  <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == CW'(BUSY_TO - 1)) begin
                  to_err <= 1'b1;
                  locked <= 1'b0;
                  active <= 1'b0;
                  state  <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  active <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a behavioural UART, a
// round-robin (optionally packet-locked) reference model feeding a scoreboard.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned IDW     = 2;
   localparam int unsigned BUSY_TO = 64;
`ifdef UART_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           resetb = 1'b0;
   logic [7:0]     tx_data;
   logic           tx_wr;
   logic           tx_busy;
   logic [IDW-1:0] grant_id;
   logic           active;
   logic           to_err;
   logic [15:0]    sent_cnt;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .BUSY_TO(BUSY_TO)) dut (
      .clk      (clk),
      .resetb   (resetb),
      .bus      (bus),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_busy  (tx_busy),
      .grant_id (grant_id),
      .active   (active),
      .to_err   (to_err),
      .sent_cnt (sent_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [8:0]  src_q[NREQ][$];
   logic [7:0]  rdat[NREQ];
   int          rise_cyc[NREQ];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   int          to_rise_cyc = 0;
   bit          lat_chk = 0;
   bit          dead = 0;
   bit          uart_run = 0;
   int          fixed_len = 0;
   logic [15:0] exp_cnt = '0;
   bit          exp_to_err = 0;
   int          m_ptr = 0;
   bit          m_locked = 0;
   int          m_lock_id = 0;
   int          b_cnt[NREQ];
   logic [7:0]  b_dat[NREQ][4];

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign bus.req_data[8*g +: 8] = rdat[g];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Requesters: present queue head, hold until ack, then advance
   initial begin
      bus.req = '0;
      bus.req_last = '0;
      for (int i = 0; i < NREQ; i++) begin rdat[i] = '0; rise_cyc[i] = 0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               if (!bus.req[i]) rise_cyc[i] = cyc;
               bus.req[i]      = 1'b1;
               rdat[i]         = src_q[i][0][7:0];
               bus.req_last[i] = src_q[i][0][8];
            end else begin
               bus.req[i] = 1'b0;
            end
         end
      end
   end

   // Behavioural UART: after tx_wr go busy for a frame, unless modelled dead
   initial begin
      int d, len;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_wr && !dead) begin
            uart_run = 1;
            d = $urandom_range(0, 2);
            repeat (d) @(negedge clk);
            tx_busy = 1'b1;
            len = (fixed_len > 0) ? fixed_len : $urandom_range(3, 12);
            repeat (len) @(negedge clk);
            tx_busy = 1'b0;
            if (resetb) exp_cnt = exp_cnt + 16'd1;
            uart_run = 0;
         end
      end
   end

   // Monitor: every tx_wr pops one expected byte; ack only alongside tx_wr
   initial begin
      forever begin
         @(negedge clk);
         if (tx_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx: got data=%h ack=%b, no byte expected", tx_data, bus.ack);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (tx_data !== e.data || grant_id !== IDW'(e.id) || bus.ack !== (NREQ'(1) << e.id)) begin
                  errors++;
                  $display("FAIL tx_byte: got id=%0d data=%h ack=%b, expected id=%0d data=%h ack=%b",
                           grant_id, tx_data, bus.ack, e.id, e.data, NREQ'(1) << e.id);
               end
               if (lat_chk) begin
                  lat_chk = 0;
                  checks++;
                  if (cyc - rise_cyc[e.id] != 2) begin
                     errors++;
                     $display("FAIL latency: got %0d cycles, expected 2", cyc - rise_cyc[e.id]);
                  end
               end
            end
            last_wr_cyc = cyc;
         end else if (bus.ack !== '0) begin
            checks++;
            errors++;
            $display("FAIL stray_ack: got ack=%b with tx_wr=0, expected 0", bus.ack);
         end
      end
   end

   // Record the cycle in which to_err rises
   initial begin
      bit prev;
      prev = 0;
      forever begin
         @(negedge clk);
         if (to_err && !prev) to_rise_cyc = cyc;
         prev = to_err;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference model: serve pending bytes round-robin from last grant + 1;
   // with the lock feature a packet runs to its last byte before others are served
   task automatic model_batch();
      int rem[NREQ];
      int sent[NREQ];
      int total;
      int pick;
      bit last;
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = b_cnt[i];
         sent[i] = 0;
         total += b_cnt[i];
         for (int s = 0; s < b_cnt[i]; s++)
            src_q[i].push_back({(s == b_cnt[i] - 1) ? 1'b1 : 1'b0, b_dat[i][s]});
      end
      while (total > 0) begin
         pick = -1;
         if (m_locked) pick = m_lock_id;
         for (int k = 0; k < NREQ; k++)
            if (pick < 0 && rem[(m_ptr + k) % NREQ] > 0) pick = (m_ptr + k) % NREQ;
         last = (rem[pick] == 1);
         exp_q.push_back('{id: pick, data: b_dat[pick][sent[pick]]});
         m_ptr = (pick + 1) % NREQ;
         rem[pick]--;
         sent[pick]++;
         total--;
         m_locked  = LOCK_EN && !last;
         m_lock_id = pick;
      end
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || active || tx_busy || uart_run || bus.req != '0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d bytes outstanding after %0d cycles, expected 0", name, exp_q.size(), n);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_batch(input string name);
      @(posedge clk);
      #1;
      model_batch();
      wait_quiet(name);
      check({name, "_sent_cnt"}, 32'(sent_cnt), 32'(exp_cnt));
      check({name, "_to_err"}, 32'(to_err), 32'(exp_to_err));
   endtask

   task automatic clear_batch();
      for (int i = 0; i < NREQ; i++) begin
         b_cnt[i] = 0;
         for (int s = 0; s < 4; s++) b_dat[i][s] = 8'(i * 16 + s);
      end
   endtask

   task automatic random_batches(input int n);
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < NREQ; i++) begin
            b_cnt[i] = $urandom_range(0, 3);
            for (int s = 0; s < 4; s++) b_dat[i][s] = 8'($urandom);
         end
         run_batch("random");
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_tx_wr"},    32'(tx_wr),    32'h0);
      check({name, "_tx_data"},  32'(tx_data),  32'h0);
      check({name, "_ack"},      32'(bus.ack),  32'h0);
      check({name, "_grant_id"}, 32'(grant_id), 32'h0);
      check({name, "_active"},   32'(active),   32'h0);
      check({name, "_to_err"},   32'(to_err),   32'h0);
      check({name, "_sent_cnt"}, 32'(sent_cnt), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish by 2 ms, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clear_batch();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_active", 32'(active), 32'h0);

      // Packet interleave (plain RR) or contiguity (locked)
      clear_batch();
      b_cnt[0] = 3;
      b_cnt[2] = 2;
      run_batch("lock");

      // Single byte, 10-cycle frame, two-cycle request-to-write latency
      clear_batch();
      fixed_len = 10;
      b_cnt[1] = 1;
      b_dat[1][0] = 8'h41;
      lat_chk = 1;
      run_batch("single");
      check("single_latency_done", 32'(lat_chk), 32'h0);
      fixed_len = 0;

      // All four requesters hold one byte each; requester 0 has a second
      clear_batch();
      b_cnt[0] = 2; b_cnt[1] = 1; b_cnt[2] = 1; b_cnt[3] = 1;
      for (int i = 0; i < NREQ; i++) begin
         b_dat[i][0] = 8'(8'h10 + i);
         b_dat[i][1] = 8'(8'h10 + i);
      end
      run_batch("rr");

      random_batches(12);

      // Dead transmitter: abort after BUSY_TO cycles, no count
      clear_batch();
      dead = 1;
      exp_to_err = 1;
      b_cnt[2] = 1;
      b_dat[2][0] = 8'h5A;
      run_batch("timeout");
      check("timeout_cycles", 32'(to_rise_cyc - last_wr_cyc), 32'(BUSY_TO));
      dead = 0;
      m_locked = 0;

      random_batches(6);

      // Counter wrap from a preloaded value
      force dut.sent_cnt = 16'hFFFE;
      @(negedge clk);
      @(negedge clk);
      release dut.sent_cnt;
      exp_cnt = 16'hFFFE;
      clear_batch();
      b_cnt[3] = 1;
      run_batch("wrap_ffff");
      clear_batch();
      b_cnt[1] = 1;
      run_batch("wrap_0000");

      // Reset while the transmitter is shifting the frame
      clear_batch();
      fixed_len = 20;
      b_cnt[3] = 1;
      b_dat[3][0] = 8'hC3;
      @(posedge clk);
      #1;
      model_batch();
      n = 0;
      while (!(tx_busy && active) && n < 200) begin @(negedge clk); n++; end
      check("reset_reached_wait_done", 32'(n < 200), 32'h1);
      @(negedge clk);
      #2;
      resetb = 1'b0;
      #1;
      check_reset_outputs("reset_mid_frame");
      n = 0;
      while ((tx_busy || uart_run) && n < 200) begin @(negedge clk); n++; end
      exp_q.delete();
      exp_cnt = '0;
      exp_to_err = 0;
      m_ptr = 0;
      m_locked = 0;
      fixed_len = 0;
      @(negedge clk);
      resetb = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_active", 32'(active), 32'h0);

      random_batches(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
